prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter width, default 9, giving instruction word width and instruction address width.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1, load-stream word present.
REQ-005 SHALL have port in_data, input, width, load-stream word.
REQ-006 SHALL have port in_ready, output, 1, loader accepts in_data this cycle.
REQ-007 SHALL have port abort, input, 1, synchronous cancel of a load in progress.
REQ-008 SHALL have port mem_we, output, 1, instruction-memory write strobe.
REQ-009 SHALL have port mem_addr, output, width, instruction-memory write address.
REQ-010 SHALL have port mem_wdata, output, width, instruction-memory write data.
REQ-011 SHALL have port start, output, 1, one-cycle launch pulse to the fetch unit.
REQ-012 SHALL have port start_addr, output, width, entry address presented with start.
REQ-013 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-014 SHALL have port err, output, 1, sticky load-error flag.

Function
REQ-015 SHALL implement FSM states IDLE, BASE, LEN, ENTRY, DATA, CHECK, LAUNCH.
- Stream order: base address, length N, entry address, N instruction words, then optional checksum.
REQ-016 SHALL accept a word only when in_valid and in_ready are both high; in_ready SHALL be high in BASE, LEN, ENTRY, DATA and CHECK, and low in IDLE and LAUNCH.
REQ-017 SHALL move IDLE->BASE when in_valid is high while in IDLE; the IDLE-cycle word is not consumed.
REQ-018 SHALL, on acceptance in BASE, LEN or ENTRY, latch the word and advance to the next state.
REQ-019 SHALL, after ENTRY, go to DATA if N>0; if N=0 it SHALL go to CHECK (macro defined) or LAUNCH (macro undefined) with no memory writes.
REQ-020 SHALL, for the k-th DATA word accepted (k=0..N-1), assert mem_we for exactly one cycle on the following cycle, with mem_addr=(base+k) mod 2^width and mem_wdata equal to that word.
REQ-021 SHALL accept one DATA word per cycle at full throughput; in_valid gaps insert no writes.
REQ-022 SHALL, after the N-th DATA word, leave DATA for CHECK or LAUNCH per REQ-019.
REQ-023 SHALL treat mem_addr wrap past 2^width-1 to 0 as legal, with no error.
REQ-024 SHALL, in LAUNCH, assert start for exactly one cycle with start_addr=entry; the next state SHALL be IDLE.
REQ-025 SHALL hold start_addr at the last launched entry value until the next launch.
REQ-026 SHALL, on abort high in any non-IDLE state, return to IDLE on the next edge, drop in_ready, and never pulse start.
- A write already registered from an earlier acceptance still completes.
REQ-027 SHALL set err on abort or on a checksum mismatch; err SHALL clear when the next load leaves IDLE.
REQ-028 SHALL give abort priority over a simultaneous word acceptance; that word is discarded.

Reset
REQ-029 SHALL, while rst_n is low, force state IDLE and drive in_ready, mem_we, start, busy, err to 0 and mem_addr, mem_wdata, start_addr to 0, independent of clk.
REQ-030 SHALL, on reset mid-load, discard all latched header and count state; no start pulse follows reset.

Configuration
REQ-031 SHALL support macro PROG_LOADER_CHECKSUM_EN.
- Defined: after the data words, the loader SHALL accept one checksum word in CHECK, compared against the XOR of all N data words (0 when N=0). Match -> LAUNCH; mismatch -> set err and go to IDLE without start.
- Undefined: the CHECK state and the checksum logic are absent, and DATA or ENTRY goes directly to LAUNCH.

Verification
REQ-032 SHALL cover a basic load: stream 0x010, 3, 0x010, 0x1A0, 0x0B1, 0x0C2 (+checksum 0x1D3 if enabled) -> writes at 0x010..0x012, then start pulse with start_addr=0x010.
REQ-033 SHALL cover wrap-around: base 0x1FE, N=4 -> writes at 0x1FE, 0x1FF, 0x000, 0x001, and err stays 0.
REQ-034 SHALL cover a zero-length load: base 0x020, N=0, entry 0x005 (+checksum 0) -> no mem_we, then start with start_addr=0x005.
REQ-035 SHALL cover abort: assert abort after the 2nd of 5 data words -> exactly 2 writes, no start, err=1, busy=0 next cycle.
REQ-036 SHALL cover a bad checksum (macro defined): checksum 0x000 for data 0x001, 0x002 -> 2 writes, no start, err=1.
REQ-037 SHALL cover async reset: drop rst_n mid-DATA between clock edges -> outputs zero immediately, and a full new load then succeeds.

Source files
------------

// File: rtl/prog_loader.sv
// Program loader: parses a base/length/entry header from a valid/ready word
// stream, writes N words to instruction memory, then launches the fetch unit.
// Optional checksum stage is compiled in with `define PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter int width = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [width-1:0] in_data,
    output logic             in_ready,
    input  logic             abort,
    output logic             mem_we,
    output logic [width-1:0] mem_addr,
    output logic [width-1:0] mem_wdata,
    output logic             start,
    output logic [width-1:0] start_addr,
    output logic             busy,
    output logic             err
);

`ifdef PROG_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE, BASE, LEN, ENTRY, DATA, CHECK, LAUNCH
    } state_t;
    localparam state_t AFTER_DATA = CHECK;
`else
    typedef enum logic [2:0] {
        IDLE, BASE, LEN, ENTRY, DATA, LAUNCH
    } state_t;
    localparam state_t AFTER_DATA = LAUNCH;
`endif

    localparam logic [width-1:0] ONE = {{(width-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [width-1:0] base_q, base_d;
    logic [width-1:0] len_q, len_d;
    logic [width-1:0] entry_q, entry_d;
    logic [width-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [width-1:0] addr_q, addr_d;
    logic [width-1:0] wdata_q, wdata_d;
    logic [width-1:0] saddr_q, saddr_d;
    logic             err_q, err_d;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [width-1:0] csum_q, csum_d;
`endif
    logic             accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            len_q   <= '0;
            entry_q <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            saddr_q <= '0;
            err_q   <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            entry_q <= entry_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            saddr_q <= saddr_d;
            err_q   <= err_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    always_comb begin
        in_ready = (state_q != IDLE) && (state_q != LAUNCH);
        accept   = in_valid && in_ready;
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        entry_d = entry_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        saddr_d = saddr_q;
        err_d   = err_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        // Abort outranks any word presented in the same cycle.
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    state_d = BASE;
                    err_d   = 1'b0;
                end
                BASE: if (accept) begin
                    base_d  = in_data;
                    state_d = LEN;
                end
                LEN: if (accept) begin
                    len_d   = in_data;
                    state_d = ENTRY;
                end
                ENTRY: if (accept) begin
                    entry_d = in_data;
                    cnt_d   = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                    state_d = (len_q == '0) ? AFTER_DATA : DATA;
                end
                DATA: if (accept) begin
                    we_d    = 1'b1;
                    addr_d  = base_q + cnt_q;
                    wdata_d = in_data;
                    cnt_d   = cnt_q + ONE;
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ in_data;
`endif
                    if (cnt_q == len_q - ONE) state_d = AFTER_DATA;
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                CHECK: if (accept) begin
                    if (in_data == csum_q) begin
                        state_d = LAUNCH;
                    end else begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end
`endif
                LAUNCH: begin
                    saddr_d = entry_q;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // start_addr shows the new entry during the pulse, then holds it in saddr_q.
    always_comb begin
        start      = (state_q == LAUNCH) && !abort;
        start_addr = start ? entry_q : saddr_q;
        busy       = (state_q != IDLE);
        err        = err_q;
        mem_we     = we_q;
        mem_addr   = addr_q;
        mem_wdata  = wdata_q;
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader (width 9); checksum words are
// streamed only when PROG_LOADER_CHECKSUM_EN is defined.
module tb_prog_loader;
    logic       clk, rst_n, in_valid, in_ready, abort;
    logic [8:0] in_data, mem_addr, mem_wdata, start_addr;
    logic       mem_we, start, busy, err;
    int         tests = 0;
    int         fails = 0;
    logic [8:0] wa[$], wd[$], sa[$];

    prog_loader #(.width(9)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .abort(abort), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .start(start), .start_addr(start_addr),
        .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
        end
        if (start) sa.push_back(start_addr);
    end

    task automatic clear_logs();
        wa.delete(); wd.delete(); sa.delete();
    endtask

    task automatic send(input logic [8:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) begin
            fails++;
            $display("FAIL send_timeout word=%h in_ready stayed %b, required 1", d, in_ready);
        end else begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        in_valid = 1'b0;
        while (busy && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) begin
            fails++;
            $display("FAIL idle_timeout busy=%b, required 0", busy);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; abort = 1'b0;
        #3;
        tests++;
        if ({in_ready, mem_we, start, busy, err} !== 5'b0 ||
            mem_addr !== 9'h0 || mem_wdata !== 9'h0 || start_addr !== 9'h0) begin
            fails++;
            $display("FAIL reset_outputs got rdy=%b we=%b st=%b busy=%b err=%b a=%h d=%h sa=%h, required all 0",
                     in_ready, mem_we, start, busy, err, mem_addr, mem_wdata, start_addr);
        end
        #9 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [8:0] ea[3] = '{9'h010, 9'h011, 9'h012};
        logic [8:0] ed[3] = '{9'h1A0, 9'h0B1, 9'h0C2};
        clear_logs();
        send(9'h010); send(9'd3); send(9'h010);
        send(9'h1A0); send(9'h0B1); send(9'h0C2);
`ifdef PROG_LOADER_CHECKSUM_EN
        send(9'h1D3);
`endif
        wait_idle();
        tests++;
        if (wa.size() != 3 || sa.size() != 1) begin
            fails++;
            $display("FAIL basic_counts got writes=%0d starts=%0d, required 3 and 1", wa.size(), sa.size());
        end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (wa.size() > i && (wa[i] !== ea[i] || wd[i] !== ed[i])) begin
                fails++;
                $display("FAIL basic_write%0d got %h=%h, required %h=%h", i, wa[i], wd[i], ea[i], ed[i]);
            end
        end
        tests++;
        if (sa.size() > 0 && sa[0] !== 9'h010) begin
            fails++;
            $display("FAIL basic_start_addr got %h, required 010", sa[0]);
        end
        tests++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_end_flags got err=%b busy=%b, required 0 0", err, busy);
        end
    endtask

    task automatic test_abort();
        clear_logs();
        send(9'h040); send(9'd5); send(9'h007);
        send(9'h001); send(9'h002);
        in_data = 9'h003;
        abort   = 1'b1;
        @(posedge clk); #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        tests++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || err !== 1'b1) begin
            fails++;
            $display("FAIL abort_flags got busy=%b rdy=%b err=%b, required 0 0 1", busy, in_ready, err);
        end
        repeat (4) @(posedge clk);
        #1;
        tests++;
        if (wa.size() != 2 || sa.size() != 0) begin
            fails++;
            $display("FAIL abort_counts got writes=%0d starts=%0d, required 2 and 0", wa.size(), sa.size());
        end else begin
            tests++;
            if (wa[0] !== 9'h040 || wd[0] !== 9'h001 || wa[1] !== 9'h041 || wd[1] !== 9'h002) begin
                fails++;
                $display("FAIL abort_writes got %h=%h %h=%h, required 040=001 041=002", wa[0], wd[0], wa[1], wd[1]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [8:0] ea[4] = '{9'h1FE, 9'h1FF, 9'h000, 9'h001};
        logic [8:0] ed[4] = '{9'h011, 9'h022, 9'h033, 9'h044};
        clear_logs();
        send(9'h1FE);
        tests++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL err_clear got err=%b, required 0", err);
        end
        send(9'd4); send(9'h100);
        send(9'h011); send(9'h022);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        send(9'h033); send(9'h044);
`ifdef PROG_LOADER_CHECKSUM_EN
        send(9'h044);
`endif
        wait_idle();
        tests++;
        if (wa.size() != 4 || sa.size() != 1) begin
            fails++;
            $display("FAIL wrap_counts got writes=%0d starts=%0d, required 4 and 1", wa.size(), sa.size());
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (wa.size() > i && (wa[i] !== ea[i] || wd[i] !== ed[i])) begin
                fails++;
                $display("FAIL wrap_write%0d got %h=%h, required %h=%h", i, wa[i], wd[i], ea[i], ed[i]);
            end
        end
        tests++;
        if (err !== 1'b0 || (sa.size() > 0 && sa[0] !== 9'h100)) begin
            fails++;
            $display("FAIL wrap_end got err=%b start_addr=%h, required 0 100", err, start_addr);
        end
    endtask

    task automatic test_zero_len();
        clear_logs();
        send(9'h020); send(9'd0); send(9'h005);
`ifdef PROG_LOADER_CHECKSUM_EN
        send(9'h000);
`endif
        wait_idle();
        tests++;
        if (wa.size() != 0 || sa.size() != 1) begin
            fails++;
            $display("FAIL zero_counts got writes=%0d starts=%0d, required 0 and 1", wa.size(), sa.size());
        end else begin
            tests++;
            if (sa[0] !== 9'h005) begin
                fails++;
                $display("FAIL zero_start_addr got %h, required 005", sa[0]);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (start_addr !== 9'h005 || start !== 1'b0) begin
            fails++;
            $display("FAIL start_addr_hold got %h start=%b, required 005 0", start_addr, start);
        end
    endtask

`ifdef PROG_LOADER_CHECKSUM_EN
    task automatic test_bad_checksum();
        clear_logs();
        send(9'h050); send(9'd2); send(9'h009);
        send(9'h001); send(9'h002); send(9'h000);
        wait_idle();
        tests++;
        if (wa.size() != 2 || sa.size() != 0 || err !== 1'b1) begin
            fails++;
            $display("FAIL bad_csum got writes=%0d starts=%0d err=%b, required 2 0 1", wa.size(), sa.size(), err);
        end
    endtask
`endif

    task automatic test_async_reset();
        send(9'h060); send(9'd3); send(9'h00A); send(9'h111);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({in_ready, mem_we, start, busy, err} !== 5'b0 ||
            mem_addr !== 9'h0 || mem_wdata !== 9'h0 || start_addr !== 9'h0) begin
            fails++;
            $display("FAIL async_reset got rdy=%b we=%b busy=%b a=%h d=%h sa=%h, required all 0",
                     in_ready, mem_we, busy, mem_addr, mem_wdata, start_addr);
        end
        #4 rst_n = 1'b1;
        @(posedge clk); #1;
        clear_logs();
        send(9'h060); send(9'd3); send(9'h00A);
        send(9'h111); send(9'h222); send(9'h333);
`ifdef PROG_LOADER_CHECKSUM_EN
        send(9'h000);
`endif
        wait_idle();
        tests++;
        if (wa.size() != 3 || sa.size() != 1) begin
            fails++;
            $display("FAIL post_reset_counts got writes=%0d starts=%0d, required 3 and 1", wa.size(), sa.size());
        end else begin
            tests++;
            if (wa[0] !== 9'h060 || wa[2] !== 9'h062 || wd[2] !== 9'h333 || sa[0] !== 9'h00A) begin
                fails++;
                $display("FAIL post_reset_load got a0=%h a2=%h d2=%h sa=%h, required 060 062 333 00a",
                         wa[0], wa[2], wd[2], sa[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        send(9'h100); send(9'd2); send(9'h101); send(9'h0AA); send(9'h055);
`ifdef PROG_LOADER_CHECKSUM_EN
        send(9'h0FF);
`endif
        send(9'h180); send(9'd1); send(9'h181); send(9'h123);
`ifdef PROG_LOADER_CHECKSUM_EN
        send(9'h123);
`endif
        wait_idle();
        tests++;
        if (wa.size() != 3 || sa.size() != 2) begin
            fails++;
            $display("FAIL b2b_counts got writes=%0d starts=%0d, required 3 and 2", wa.size(), sa.size());
        end else begin
            tests++;
            if (wa[1] !== 9'h101 || wd[1] !== 9'h055 || wa[2] !== 9'h180 || wd[2] !== 9'h123 ||
                sa[0] !== 9'h101 || sa[1] !== 9'h181) begin
                fails++;
                $display("FAIL b2b_values got %h=%h %h=%h starts %h %h, required 101=055 180=123 starts 101 181",
                         wa[1], wd[1], wa[2], wd[2], sa[0], sa[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_abort();
        test_wrap();
        test_zero_len();
`ifdef PROG_LOADER_CHECKSUM_EN
        test_bad_checksum();
`endif
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
